piso_tx: RTL
============

Name: piso_tx

Overview:
- Parallel-in/serial-out transmitter: the sending end of the serial link whose receiving end is the 4-bit SIPO register.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per enabled clock, with a bit-valid strobe.
- Sits between a parallel data source and the serial line feeding a SIPO; its `out` connects to the SIPO `inp`.

Parameters:
- WIDTH, 4, data word width in bits (>=2).
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous reset, active-high.
- enb  input  1  shift/accept enable; when 0, all state holds.
- load  input  1  source has a valid word on din.
- din  input  WIDTH  parallel word to transmit.
- ready  output  1  transmitter can accept a word this cycle.
- out  output  1  serial data bit.
- out_vld  output  1  out carries a valid data (or parity) bit.
- busy  output  1  a word is in flight.
- done  output  1  one-cycle pulse: the last bit of a word has retired.

Behaviour:
- Reset: clk single clock. rst is asynchronous and active-high.
  - While rst=1: state=IDLE, shift register=0, bit counter=0, out=0, out_vld=0, busy=0, done=0.
  - ready is combinational and reads 1 in IDLE.
- States: IDLE, SHIFT.
- Transfer rule:
  - A word is accepted on a rising edge where load=1, ready=1 and enb=1.
  - din is sampled on that edge. load has no effect at any other time.
- ready = (state==IDLE) or (state==SHIFT and counter==LAST), where LAST = WIDTH-1, or WIDTH with the parity option.
  - ready does not depend on enb or load.
- IDLE -> SHIFT on acceptance. After that edge:
  - out = first bit (din[WIDTH-1] if MSB_FIRST, else din[0]).
  - out_vld=1, busy=1, counter=0.
- In SHIFT, on each edge with enb=1:
  - If counter<LAST: shift to the next bit in order, counter+1.
  - If counter==LAST and a transfer occurs: load the new word at once, counter=0, done=1 for one cycle. Back-to-back words have no gap bit.
  - If counter==LAST and no transfer: go to IDLE, out=0, out_vld=0, busy=0, done=1 for one cycle.
- enb=0: out, out_vld, counter and state all hold. No transfer can occur. done is cleared on the next edge regardless of enb.
- Bit period: each bit stays on out for exactly the number of clocks until the next enb=1 edge. With enb held high, a word takes WIDTH clocks.
- Idle line level: out=0.
- All outputs except ready are registered. Latency from the accepting edge to the first valid bit is 0 clocks (visible right after that edge).
- Asserting rst mid-word aborts the word immediately:
  - No done pulse.
  - After release, the block is in IDLE and ready=1.
- Counter width: $clog2(WIDTH+1) bits. The counter never exceeds LAST.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined: LAST=WIDTH.
  - After the WIDTH data bits, one extra bit is sent: even parity = XOR of all din bits, computed at acceptance.
  - out_vld=1 during the parity bit. done fires after the parity bit.
  - A word occupies WIDTH+1 enabled clocks.
- Undefined: no parity bit. LAST=WIDTH-1. No parity logic is synthesized.

Test Plan:
- WIDTH=4, MSB_FIRST=1, enb=1; load din=4'b1011 for one clock from IDLE -> out=1,0,1,1 on 4 consecutive clocks; out_vld=1 for exactly 4 clocks; done=1 on the 5th clock; then out=0, out_vld=0, ready=1.
- Same word, with enb=0 for 3 clocks after the second bit -> out holds 0 and out_vld holds 1 for those 3 clocks; sequence resumes 1,1; total 7 clocks; a single done pulse.
- Back-to-back: load 4'b1011, then hold load=1 with din=4'b0110 while ready is high on the last bit -> 8 contiguous bits 1,0,1,1,0,1,1,0; out_vld continuous; done pulses after bit 4 and bit 8; busy never drops between the words.
- load=1 with din=4'b1111 while counter=1 (ready=0) -> ignored; the current word completes unchanged.
- rst asserted asynchronously mid-clock during bit 2 of 4'b1011 -> out=0, out_vld=0, busy=0 immediately; no done pulse; ready=1 after release.
- PISO_PARITY_EN defined, MSB_FIRST=0, din=4'b1011 -> out=1,1,0,1, then parity bit 1; out_vld=1 for 5 clocks; done on the 6th clock.

Source files
------------

// File: rtl/piso_tx.sv
// piso_tx: parallel-in/serial-out transmitter feeding a SIPO receiver.
// Accepts a WIDTH-bit word over a valid/ready handshake (load/ready) and
// shifts it out one bit per enabled clock on `out`, qualified by `out_vld`.
// Optional feature macro: PISO_PARITY_EN -- appends one even-parity bit
// after the data bits (word then occupies WIDTH+1 enabled clocks).
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             out,
  output logic             out_vld,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam logic [CW-1:0] LAST_C = CW'(LAST);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Bit shifted into the vacated end of the shift register at acceptance.
  // With parity enabled it is the even parity of the word, so it naturally
  // emerges right after the last data bit with no special-case path.
  logic fill_bit;
`ifdef PISO_PARITY_EN
  assign fill_bit = ^din;
`else
  assign fill_bit = 1'b0;
`endif

  // Shift register holds the bits still to be sent after the one on `out`.
  logic             first_bit;
  logic [WIDTH-1:0] load_shreg;
  logic             next_bit;
  logic [WIDTH-1:0] shifted;
  logic             accept;

  assign first_bit  = MSB_FIRST ? din[WIDTH-1] : din[0];
  assign load_shreg = MSB_FIRST ? {din[WIDTH-2:0], fill_bit}
                                : {fill_bit, din[WIDTH-1:1]};
  assign next_bit   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shifted    = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shreg_q[WIDTH-1:1]};

  // Ready in IDLE, or on the last bit of a word so the next word follows gap-free.
  assign ready  = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST_C));
  assign accept = load && ready && enb;

  // Next-state logic: accept, shift, retire; everything holds while enb=0.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (enb) begin
      if ((state_q == SHIFT) && (cnt_q < LAST_C)) begin
        out_d   = next_bit;
        shreg_d = shifted;
        cnt_d   = cnt_q + CW'(1);
      end else begin
        // Either IDLE, or SHIFT on the last bit: a word retires here.
        if (state_q == SHIFT) begin
          done_d = 1'b1;
        end
        if (accept) begin
          state_d = SHIFT;
          out_d   = first_bit;
          shreg_d = load_shreg;
          cnt_d   = '0;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          out_d   = 1'b0;
          shreg_d = '0;
          cnt_d   = '0;
          vld_d   = 1'b0;
          busy_d  = 1'b0;
        end
      end
    end
  end

  // State and registered outputs; reset aborts any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out     = out_q;
  assign out_vld = vld_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
